// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states and frame-candidate kinds.
package keypad_pkg;

  // Debounced key state: nothing held, or one key held and already reported.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } scan_state_e;

  // What one full frame saw: no contact, exactly one contact, or several.
  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_KEY   = 2'd1,
    CAND_MULTI = 2'd2
  } cand_kind_e;

  // Contact counts saturate here; two is enough to know "more than one".
  localparam logic [1:0] HIT_SAT = 2'd2;

  // Map a saturated contact count onto a candidate kind.
  function automatic cand_kind_e classify(input logic [1:0] hits);
    cand_kind_e kind;
    case (hits)
      2'd0:    kind = CAND_NONE;
      2'd1:    kind = CAND_KEY;
      default: kind = CAND_MULTI;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// Free-running divider producing a one-cycle tick every FPGA_FREQ/TICK_FREQ
// clocks. The counter runs 0..DIV-1 and the tick is high while it sits at DIV-1.
module keypad_tick #(
  parameter int FPGA_FREQ = 50_000_000,
  parameter int TICK_FREQ = 4_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DIV = FPGA_FREQ / TICK_FREQ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count up and wrap at DIV-1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: drives one row at a time, collects a whole frame of
// column contacts, debounces the frame result and emits single key events
// through a valid/ready output register with a sticky overrun flag.
module keypad_scan #(
  parameter int ROW_CNT        = 4,
  parameter int COL_CNT        = 4,
  parameter int FPGA_FREQ      = 50_000_000,
  parameter int SCAN_FREQ      = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [COL_CNT-1:0]                    col_i,
  input  logic                                  key_ready_i,
  output logic [ROW_CNT-1:0]                    row_o,
  output logic                                  key_valid_o,
  output logic [$clog2(ROW_CNT*COL_CNT)-1:0]    key_code_o,
  output logic                                  pressed_o,
  output logic                                  overrun_o
);

  import keypad_pkg::*;

  localparam int CODE_W = $clog2(ROW_CNT * COL_CNT);
  localparam int ROW_W  = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
  localparam int SW     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_CNT - 1);
  localparam logic [SW-1:0]    DEB_V    = SW'(DEBOUNCE_SCANS);

  // Row dwell tick
  logic tick;

  keypad_tick #(
    .FPGA_FREQ (FPGA_FREQ),
    .TICK_FREQ (SCAN_FREQ * ROW_CNT)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Column synchronizer
  logic [COL_CNT-1:0] col_meta_q;
  logic [COL_CNT-1:0] col_sync_q;

  // Two flops between the raw switch lines and any decision logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_meta_q <= '0;
      col_sync_q <= '0;
    end else begin
      col_meta_q <= col_i;
      col_sync_q <= col_meta_q;
    end
  end

  // Row sequencing
  logic [ROW_W-1:0] row_idx_q;
  logic             frame_close;

  // Advance the driven row on every tick, wrapping after the last row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_idx_q <= '0;
    end else if (tick) begin
      row_idx_q <= (row_idx_q == ROW_LAST) ? '0 : row_idx_q + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < ROW_CNT; gi++) begin : g_row_dec
      assign row_o[gi] = (row_idx_q == ROW_W'(gi));
    end
  endgenerate

  // The tick that samples the last row also ends the frame.
  assign frame_close = tick && (row_idx_q == ROW_LAST);

  // Frame accumulation
  logic [1:0]        acc_cnt_q;
  logic [CODE_W-1:0] acc_code_q;
  logic [1:0]        hit_cnt_d;
  logic [CODE_W-1:0] hit_code_d;

  // Fold the current row's contacts into the running frame tally; the code
  // is only meaningful while exactly one contact has been seen.
  always_comb begin
    hit_cnt_d  = acc_cnt_q;
    hit_code_d = acc_code_q;
    for (int c = 0; c < COL_CNT; c++) begin
      if (col_sync_q[c]) begin
        if (hit_cnt_d == 2'd0) begin
          hit_code_d = CODE_W'(int'(row_idx_q) * COL_CNT + c);
        end
        if (hit_cnt_d != HIT_SAT) begin
          hit_cnt_d = hit_cnt_d + 2'd1;
        end
      end
    end
  end

  // Keep the tally across the rows of a frame and clear it at frame close.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (frame_close) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else if (tick) begin
      acc_cnt_q  <= hit_cnt_d;
      acc_code_q <= hit_code_d;
    end
  end

  // Debounce
  cand_kind_e        cand_kind_d;
  logic [CODE_W-1:0] cand_code_d;
  cand_kind_e        prev_kind_q;
  logic [CODE_W-1:0] prev_code_q;
  logic [SW-1:0]     stable_q;
  logic [SW-1:0]     stable_d;
  logic              debounced_d;

  // Classify the closing frame and work out its run length. Non-KEY
  // candidates carry code 0 so a plain compare tells whether frames match.
  always_comb begin
    cand_kind_d = classify(hit_cnt_d);
    cand_code_d = (cand_kind_d == CAND_KEY) ? hit_code_d : '0;
    if ((cand_kind_d == prev_kind_q) && (cand_code_d == prev_code_q)) begin
      stable_d = (stable_q == DEB_V) ? DEB_V : stable_q + 1'b1;
    end else begin
      stable_d = SW'(1);
    end
    debounced_d = (stable_d == DEB_V);
  end

  // Remember the previous frame's candidate and the saturating run length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_kind_q <= CAND_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
    end else if (frame_close) begin
      prev_kind_q <= cand_kind_d;
      prev_code_q <= cand_code_d;
      stable_q    <= stable_d;
    end
  end

  // Press/release FSM
  scan_state_e       state_q;
  logic              emit_q;
  logic [CODE_W-1:0] emit_code_q;

  // A debounced key from IDLE emits one event; only a debounced empty frame
  // releases it. MULTI or another key while held never emits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      emit_q      <= 1'b0;
      emit_code_q <= '0;
    end else begin
      emit_q <= 1'b0;
      if (frame_close) begin
        case (state_q)
          ST_IDLE: begin
            if ((cand_kind_d == CAND_KEY) && debounced_d) begin
              state_q     <= ST_HELD;
              emit_q      <= 1'b1;
              emit_code_q <= cand_code_d;
            end
          end
          ST_HELD: begin
            if ((cand_kind_d == CAND_NONE) && debounced_d) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign pressed_o = (state_q == ST_HELD);

  // Event output register
  logic              key_valid_q;
  logic [CODE_W-1:0] key_code_q;
  logic              overrun_q;

  // Load new events unless an unaccepted one is still pending, in which case
  // the new event is dropped and overrun latches. Overrun clears only on a
  // plain handshake; a handshake coinciding with a new event leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else if (emit_q) begin
      if (key_valid_q && !key_ready_i) begin
        overrun_q <= 1'b1;
      end else begin
        key_valid_q <= 1'b1;
        key_code_q  <= emit_code_q;
      end
    end else if (key_valid_q && key_ready_i) begin
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model closes column lines for
// whichever keys are held on the driven row, and a frame-level reference
// model predicts every output cycle by cycle.
module tb_keypad_scan;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NKEYS  = ROWS * COLS;
  localparam int DWELL  = 4;             // 16_000 / (1_000 * 4)
  localparam int FRAME  = DWELL * ROWS;  // 16 cycles
  localparam int DEB    = 3;
  localparam int C_NONE  = -1;
  localparam int C_MULTI = 99;

  logic              clk;
  logic              rst;
  logic [COLS-1:0]   col;
  logic              ready;
  logic [ROWS-1:0]   row;
  logic              valid;
  logic [3:0]        code;
  logic              pressed;
  logic              overrun;

  logic [NKEYS-1:0]  keys;   // keys physically held right now

  int n_checks;
  int n_errors;

  // reference model state
  int m_edge;
  int m_prev;
  int m_stable;
  bit m_held;
  bit m_valid;
  int m_code;
  bit m_ovr;
  bit m_ev;
  int m_ev_code;

  keypad_scan #(
    .ROW_CNT        (ROWS),
    .COL_CNT        (COLS),
    .FPGA_FREQ      (16_000),
    .SCAN_FREQ      (1_000),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .col_i       (col),
    .key_ready_i (ready),
    .row_o       (row),
    .key_valid_o (valid),
    .key_code_o  (code),
    .pressed_o   (pressed),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a held key shorts its row to its column.
  always_comb begin
    col = '0;
    for (int k = 0; k < NKEYS; k++) begin
      if (keys[k] && row[k / COLS]) col[k % COLS] = 1'b1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_edge);
    end
  endtask

  // What a frame holding this key set should report.
  function automatic int frame_cand(input logic [NKEYS-1:0] ks);
    int n;
    n = $countones(ks);
    if (n == 0) return C_NONE;
    if (n > 1) return C_MULTI;
    for (int k = 0; k < NKEYS; k++) if (ks[k]) return k;
    return C_NONE;
  endfunction

  task automatic model_reset();
    m_edge = 0; m_prev = C_NONE; m_stable = 0; m_held = 0;
    m_valid = 0; m_code = 0; m_ovr = 0; m_ev = 0; m_ev_code = 0;
  endtask

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    int c;
    m_edge++;
    if (m_ev) begin
      if (m_valid && !ready) begin
        m_ovr = 1;
      end else begin
        if (m_valid) $display("key %0d accepted, key %0d loaded at edge %0d", m_code, m_ev_code, m_edge);
        m_valid = 1;
        m_code  = m_ev_code;
      end
    end else if (m_valid && ready) begin
      $display("key %0d accepted at edge %0d", m_code, m_edge);
      m_valid = 0;
      m_ovr   = 0;
    end
    m_ev = 0;
    if (m_edge % FRAME == 0) begin
      c = frame_cand(keys);
      m_stable = (c == m_prev) ? ((m_stable + 1 > DEB) ? DEB : m_stable + 1) : 1;
      m_prev = c;
      if (!m_held && c >= 0 && c < NKEYS && m_stable == DEB) begin
        m_held = 1;
        m_ev = 1;
        m_ev_code = c;
      end else if (m_held && c == C_NONE && m_stable == DEB) begin
        m_held = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("row_o", int'(row), 1 << ((m_edge / DWELL) % ROWS));
    check("key_valid_o", int'(valid), int'(m_valid));
    check("key_code_o", int'(code), m_code);
    check("pressed_o", int'(pressed), int'(m_held));
    check("overrun_o", int'(overrun), int'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) step();
  endtask

  task automatic align();
    while (m_edge % FRAME != 0) step();
  endtask

  // Assert reset off-edge, check outputs immediately, release on a negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_row", int'(row), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_code", int'(code), 0);
    check("rst_pressed", int'(pressed), 0);
    check("rst_overrun", int'(overrun), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    keys  = '0;
    ready = 1'b0;
    rst   = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // clean press of key 9 (row 2, col 1), no ready
    keys = NKEYS'(1) << 9;
    frames(3);
    check("press_early_valid", int'(valid), 0);
    step();
    check("press_valid", int'(valid), 1);
    check("press_code", int'(code), 9);
    check("press_held", int'(pressed), 1);
    frames(2);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("press_accept_valid", int'(valid), 0);
    align();
    keys = '0;
    frames(4);
    check("release_held", int'(pressed), 0);

    // bounce: key 9 toggling every frame
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? (NKEYS'(1) << 9) : '0;
      frames(1);
    end
    check("bounce_valid", int'(valid), 0);
    check("bounce_held", int'(pressed), 0);
    keys = '0;
    frames(4);

    // ghost: keys 0 and 5 together
    keys = (NKEYS'(1) << 0) | (NKEYS'(1) << 5);
    frames(6);
    check("ghost_valid", int'(valid), 0);
    check("ghost_held", int'(pressed), 0);
    keys = '0;
    frames(4);

    // overrun: key 3 left pending, then key 7 dropped
    keys = NKEYS'(1) << 3;
    frames(4);
    keys = '0;
    frames(4);
    keys = NKEYS'(1) << 7;
    frames(4);
    check("ovr_code", int'(code), 3);
    check("ovr_flag", int'(overrun), 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    check("ovr_valid", int'(valid), 0);
    align();
    keys = '0;
    frames(4);

    // simultaneous: key 3 pending, key 7 emitted on the accepting edge
    keys = NKEYS'(1) << 3;
    frames(4);
    keys = '0;
    frames(4);
    keys = NKEYS'(1) << 7;
    frames(3);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("sim_code", int'(code), 7);
    check("sim_valid", int'(valid), 1);
    check("sim_overrun", int'(overrun), 0);
    align();
    keys = '0;
    frames(4);

    // reset mid-frame with a pending event and key 9 still held
    keys = NKEYS'(1) << 9;
    frames(3);
    repeat (7) step();
    do_reset();
    frames(3);
    check("rereport_early", int'(valid), 0);
    step();
    check("rereport_valid", int'(valid), 1);
    check("rereport_code", int'(code), 9);
    align();

    // randomized frames and ready
    for (int f = 0; f < 150; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 5) begin
        keys = '0;
      end else if (r >= 6 && r <= 8) begin
        keys = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
      end else if (r == 9) begin
        keys = (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) | (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
      end
      for (int cyc = 0; cyc < FRAME; cyc++) begin
        ready = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
